// File: rtl/pkt_grant_lock_mux_pkg.sv
// Shared types, default sizes and width helpers for the packet grant/lock mux.
package pkt_grant_lock_mux_pkg;

  // Arbiter-lock states: waiting for requests, or holding one requester's packet.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_N         = 4;
  localparam int DEF_W         = 32;
  localparam int DEF_MAX_BEATS = 16;

  // Width of the binary grant index; a single requester still gets one bit.
  function automatic int calc_idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the per-packet beat counter, wide enough to hold MAX_BEATS itself.
  function automatic int calc_cnt_w(input int max_beats);
    return (max_beats < 1) ? 1 : $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/pkt_grant_lock_mux_lsb_first_pick.sv
// Combinational lowest-index-wins picker: one-hot winner plus its binary index.
module lsb_first_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // seen[i] is set when some request below index i is active.
  logic [N:0] seen;

  assign seen[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pick
      assign onehot[gi]   = req[gi] & ~seen[gi];
      assign seen[gi + 1] = seen[gi] | req[gi];
    end
  endgenerate

  assign any = seen[N];

  // Encode the one-hot winner into its binary index (zero when nothing requests).
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IDW'(i);
    end
  end

endmodule

// File: rtl/pkt_grant_lock_mux.sv
// Fixed-priority packet grant with lock: picks one requester in IDLE, holds the
// grant for the whole packet, and muxes its beats onto one valid/ready channel.
module pkt_grant_lock_mux
  import pkt_grant_lock_mux_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int W         = DEF_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  localparam int IDW      = calc_idw(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_last,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [N-1:0]     grant,
  output logic [IDW-1:0]   grant_id,
  output logic             err_overrun
);

  localparam int CW = calc_cnt_w(MAX_BEATS);

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            err_overrun_q, err_overrun_d;

  logic [N-1:0]    pick_onehot;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;

  logic [W-1:0]    masked_data [N];
  logic [W-1:0]    sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            accept;

  lsb_first_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (in_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // AND-OR mux: the registered one-hot grant gates each requester's data.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign masked_data[gi] = in_data[gi*W +: W] & {W{grant_q[gi]}};
    end
  endgenerate

  // OR together the gated lanes; only the granted lane can be non-zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | masked_data[i];
    end
  end

  assign sel_valid = |(in_valid & grant_q);
  assign sel_last  = |(in_last & grant_q);
  assign accept    = (state_q == LOCKED) && sel_valid && out_ready;

  // Next-state and channel outputs; the last/forced-release paths both go back to IDLE.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    beat_cnt_d    = beat_cnt_q;
    err_overrun_d = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;
    in_ready      = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = LOCKED;
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
        end
      end
      LOCKED: begin
        out_valid = sel_valid;
        out_data  = sel_data;
        out_last  = sel_last;
        in_ready  = grant_q & {N{out_ready}};
        if (accept) begin
          if (sel_last || (beat_cnt_q == CW'(MAX_BEATS - 1))) begin
            // Packet ends here, either normally or because it ran too long.
            state_d       = IDLE;
            grant_d       = '0;
            grant_id_d    = '0;
            beat_cnt_d    = '0;
            err_overrun_d = ~sel_last;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        beat_cnt_d = '0;
      end
    endcase
  end

  // State, grant, counter and overrun-pulse registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      beat_cnt_q    <= '0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      beat_cnt_q    <= beat_cnt_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign err_overrun = err_overrun_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

// File: tb/tb_pkt_grant_lock_mux.sv
// Scenario bench for pkt_grant_lock_mux: per-requester beat sources, an
// expected-beat scoreboard, and per-cycle grant/ready/overrun tables.
module tb_pkt_grant_lock_mux;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int MB  = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             out_ready;
  logic [N-1:0]     grant;
  logic [IDW-1:0]   grant_id;
  logic             err_overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int err_cnt  = 0;

  beat_t        src_q [N][$];
  beat_t        exp_q [$];
  beat_t        mon_e;
  logic [N-1:0] hs;

  pkt_grant_lock_mux #(
    .N         (N),
    .W         (W),
    .MAX_BEATS (MB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_id    (grant_id),
    .err_overrun (err_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Handshakes seen on the falling edge decide which source heads retire.
  always @(negedge clk) hs = in_valid & in_ready;

  // Requester model: retire accepted beats (or one-cycle gaps) and present the next head.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && (hs[i] || !src_q[i][0].v)) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        in_valid[i]       = src_q[i][0].v;
        in_data[i*W +: W] = src_q[i][0].d;
        in_last[i]        = src_q[i][0].l;
      end else begin
        in_valid[i]       = 1'b0;
        in_data[i*W +: W] = '0;
        in_last[i]        = 1'b0;
      end
    end
  end

  // Scoreboard: every accepted output beat must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      acc_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_extra: got data=%h last=%b, required no beat", out_data, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_data, out_last} !== {mon_e.d, mon_e.l}) begin
          n_fail++;
          $display("FAIL scoreboard_beat: got data=%h last=%b, required data=%h last=%b",
                   out_data, out_last, mon_e.d, mon_e.l);
        end else begin
          $display("beat ok data=%h last=%b", out_data, out_last);
        end
      end
    end
    if (err_overrun === 1'b1) err_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Queue a packet on requester r and record its beats as expected output.
  task automatic push_pkt(input int r, input logic [W-1:0] d0, input int n, input int last_at);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.v = 1'b1;
      b.d = d0 + W'(k);
      b.l = (k == last_at);
      src_q[r].push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic push_gap(input int r);
    beat_t b;
    b = '0;
    src_q[r].push_back(b);
  endtask

  task automatic test_reset();
    beat_t b;
    rst_n     = 1'b1;
    out_ready = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    hs        = '0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      b.v = 1'b1;
      b.d = $urandom;
      b.l = 1'($urandom_range(0, 1));
      src_q[i].push_back(b);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      out_ready = 1'($urandom_range(0, 1));
      smp();
      n_checks++;
      if ({grant, grant_id, out_valid, in_ready, err_overrun, out_data, out_last} !== '0) begin
        n_fail++;
        $display("FAIL reset_values: grant=%b id=%0d ov=%b ir=%b err=%b data=%h last=%b, required all zero",
                 grant, grant_id, out_valid, in_ready, err_overrun, out_data, out_last);
      end
    end
    step();
    for (int i = 0; i < N; i++) src_q[i].delete();
    smp();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      smp();
      n_checks++;
      if (grant !== '0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: grant=%b ov=%b, required grant=0000 ov=0", grant, out_valid);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_priority();
    logic [N-1:0]   eg [7];
    logic [IDW-1:0] ei [7];
    eg = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
    ei = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd3, 2'd0};
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 0) begin
        out_ready = 1'b1;
        push_pkt(1, 32'h0000_00A1, 3, 2);
        push_pkt(3, 32'h0000_00B1, 1, 0);
      end
      smp();
      n_checks++;
      if (grant !== eg[k] || grant_id !== ei[k]) begin
        n_fail++;
        $display("FAIL priority_grant cyc %0d: grant=%b id=%0d, required grant=%b id=%0d",
                 k, grant, grant_id, eg[k], ei[k]);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL priority_drain: %0d beats outstanding, required 0", exp_q.size());
    end
    $display("test_priority done");
  endtask

  task automatic test_lock_hold();
    logic [N-1:0] eg [9];
    logic         ov [9];
    eg = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
    ov = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 0) begin
        push_pkt(2, 32'h0000_00C1, 1, -1);
        push_gap(2);
        push_pkt(2, 32'h0000_00C2, 3, 2);
      end
      if (k == 2) push_pkt(0, 32'h0000_00D1, 1, 0);
      smp();
      n_checks++;
      if (grant !== eg[k] || out_valid !== ov[k] || in_ready !== eg[k]) begin
        n_fail++;
        $display("FAIL lock_hold cyc %0d: grant=%b ov=%b ir=%b, required grant=%b ov=%b ir=%b",
                 k, grant, out_valid, in_ready, eg[k], ov[k], eg[k]);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lock_drain: %0d beats outstanding, required 0", exp_q.size());
    end
    $display("test_lock_hold done");
  endtask

  task automatic test_backpressure();
    logic         orr [6];
    logic [N-1:0] eg  [6];
    logic [N-1:0] eir [6];
    int           acc0;
    orr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    eg  = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    eir = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    acc0 = acc_cnt;
    for (int k = 0; k < 6; k++) begin
      step();
      out_ready = orr[k];
      if (k == 0) push_pkt(1, 32'h0000_00E1, 2, 1);
      smp();
      n_checks++;
      if (grant !== eg[k] || in_ready !== eir[k]) begin
        n_fail++;
        $display("FAIL backpressure cyc %0d: grant=%b ir=%b, required grant=%b ir=%b",
                 k, grant, in_ready, eg[k], eir[k]);
      end
      if (k == 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_00E2 || out_last !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: ov=%b data=%h last=%b, required ov=1 data=000000e2 last=1",
                   out_valid, out_data, out_last);
        end
      end
    end
    out_ready = 1'b1;
    n_checks++;
    if (acc_cnt - acc0 != 2) begin
      n_fail++;
      $display("FAIL backpressure_count: %0d beats accepted, required 2", acc_cnt - acc0);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_overrun();
    logic [N-1:0] eg [12];
    logic         ee [12];
    eg = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
           4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    ee = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 0) push_pkt(1, 32'h0000_00F1, 8, -1);
      smp();
      n_checks++;
      if (grant !== eg[k] || err_overrun !== ee[k]) begin
        n_fail++;
        $display("FAIL overrun cyc %0d: grant=%b err=%b, required grant=%b err=%b",
                 k, grant, err_overrun, eg[k], ee[k]);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL overrun_drain: %0d beats outstanding, required 0", exp_q.size());
    end
    $display("test_overrun done");
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] eg [5];
    int           err0;
    eg = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
    err0 = err_cnt;
    step();
    push_pkt(2, 32'h0000_0071, 5, 4);
    smp();
    step();
    smp();
    step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== '0 || out_valid !== 1'b0 || in_ready !== '0 || out_data !== '0 || err_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: grant=%b ov=%b ir=%b data=%h err=%b, required all zero",
               grant, out_valid, in_ready, out_data, err_overrun);
    end
    smp();
    step();
    #2 rst_n = 1'b1;
    smp();
    n_checks++;
    if (grant !== '0) begin
      n_fail++;
      $display("FAIL reset_release: grant=%b, required 0000", grant);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      smp();
      n_checks++;
      if (grant !== eg[k]) begin
        n_fail++;
        $display("FAIL mid_reset cyc %0d: grant=%b, required %b", k, grant, eg[k]);
      end
    end
    n_checks++;
    if (err_cnt != err0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_tail: %0d overrun pulses and %0d beats outstanding, required 0 and 0",
               err_cnt - err0, exp_q.size());
    end
    $display("test_mid_reset done");
  endtask

  initial begin
    test_reset();
    test_priority();
    test_lock_hold();
    test_backpressure();
    test_overrun();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
